// File: rtl/noc_pkg.sv
// Shared NoC definitions: port count, port codes and the crossbar "no source" select.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_W    = 3;

    typedef enum logic [PORT_W-1:0] {
        N = 3'd0,
        S = 3'd1,
        E = 3'd2,
        W = 3'd3,
        L = 3'd4
    } port_e;

    localparam logic [PORT_W-1:0] SEL_NONE = 3'b111;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    // Next port code in round-robin order, wrapping L back to N.
    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-way round-robin arbiter: highest priority at i_ptr, then i_ptr+1 ... mod 5.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PORT_W-1:0]    i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [PORT_W-1:0]    o_gnt_idx,
    output logic                 o_valid
);

    logic [PORT_W-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_valid   = 1'b0;
        w_idx     = i_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!o_valid && i_req[w_idx]) begin
                o_valid   = 1'b1;
                o_gnt_idx = w_idx;
            end
            w_idx = port_inc(w_idx);
        end
        if (o_valid) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/noc_switch_alloc.sv
// Wormhole switch allocator: one IDLE/LOCKED FSM and round-robin arbiter per output port.
module noc_switch_alloc
    import noc_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS*PORT_W-1:0]   dest_i,
    input  logic [NUM_PORTS-1:0]          tail_i,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [NUM_PORTS*PORT_W-1:0]   port_select_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    output logic [NUM_PORTS-1:0]          err_o
);

    logic [NUM_PORTS-1:0] w_legal;
    logic [NUM_PORTS-1:0] w_illegal;
    logic [NUM_PORTS-1:0] w_req_to [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_gnt    [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_err;
    logic [PORT_W-1:0]    w_dest;

    // Classify each request and build the per-output requester bitmaps.
    always_comb begin
        w_legal   = '0;
        w_illegal = '0;
        w_dest    = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_req_to[o] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dest = dest_i[i*PORT_W +: PORT_W];
            if (req_i[i]) begin
                if ((w_dest <= 3'd4) && (w_dest != PORT_W'(i))) begin
                    w_legal[i] = 1'b1;
                end else begin
                    w_illegal[i] = 1'b1;
                end
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_legal[i] && (w_dest == PORT_W'(o))) begin
                    w_req_to[o][i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= w_illegal;
        end
    end

    assign err_o = r_err;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        out_state_e           r_state;
        out_state_e           w_state_nxt;
        logic [PORT_W-1:0]    r_owner;
        logic [PORT_W-1:0]    w_owner_nxt;
        logic [PORT_W-1:0]    r_ptr;
        logic [PORT_W-1:0]    w_ptr_nxt;
        logic [NUM_PORTS-1:0] w_arb_gnt;
        logic [PORT_W-1:0]    w_arb_idx;
        logic                 w_arb_vld;
        logic                 w_xfer;
        logic [PORT_W-1:0]    w_src;
        logic [NUM_PORTS-1:0] w_gnt_loc;

        rr_arbiter u_arb (
            .i_req     (w_req_to[o]),
            .i_ptr     (r_ptr),
            .o_gnt     (w_arb_gnt),
            .o_gnt_idx (w_arb_idx),
            .o_valid   (w_arb_vld)
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= OUT_IDLE;
                r_owner <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_ptr   <= w_ptr_nxt;
            end
        end

        // A locked output ignores everyone but its owner until the owner sends its tail.
        always_comb begin
            w_state_nxt = r_state;
            w_owner_nxt = r_owner;
            w_ptr_nxt   = r_ptr;
            w_xfer      = 1'b0;
            w_src       = r_owner;
            w_gnt_loc   = '0;
            case (r_state)
                OUT_IDLE: begin
                    if (w_arb_vld && out_ready_i[o]) begin
                        w_xfer    = 1'b1;
                        w_src     = w_arb_idx;
                        w_gnt_loc = w_arb_gnt;
                        if (tail_i[w_arb_idx]) begin
                            w_ptr_nxt = port_inc(w_arb_idx);
                        end else begin
                            w_state_nxt = OUT_LOCKED;
                            w_owner_nxt = w_arb_idx;
                        end
                    end
                end
                OUT_LOCKED: begin
                    if (w_req_to[o][r_owner] && out_ready_i[o]) begin
                        w_xfer             = 1'b1;
                        w_gnt_loc[r_owner] = 1'b1;
                        if (tail_i[r_owner]) begin
                            w_state_nxt = OUT_IDLE;
                            w_ptr_nxt   = port_inc(r_owner);
                        end
                    end
                end
                default: begin
                    w_state_nxt = OUT_IDLE;
                end
            endcase
            if (reset) begin
                w_xfer    = 1'b0;
                w_gnt_loc = '0;
            end
        end

        assign w_gnt[o]                        = w_gnt_loc;
        assign out_valid_o[o]                  = w_xfer;
        assign port_select_o[o*PORT_W +: PORT_W] = w_xfer ? w_src : SEL_NONE;
    end

    always_comb begin
        grant_o = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_o = grant_o | w_gnt[o];
        end
    end

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed scoreboard bench for noc_switch_alloc: expected outputs queued per step, checked mid-cycle.
module tb_noc_switch_alloc;
    import noc_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  req_i;
    logic [14:0] dest_i;
    logic [4:0]  tail_i;
    logic [4:0]  out_ready_i;
    logic [4:0]  grant_o;
    logic [14:0] port_select_o;
    logic [4:0]  out_valid_o;
    logic [4:0]  err_o;

    typedef struct {
        logic [4:0]  gnt;
        logic [14:0] sel;
        logic [4:0]  vld;
        logic [4:0]  err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    localparam logic [2:0] NN  = 3'b111;
    localparam logic [2:0] X0  = 3'b000;
    localparam logic [4:0] ALL = 5'b11111;

    noc_switch_alloc dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_i),
        .dest_i        (dest_i),
        .tail_i        (tail_i),
        .out_ready_i   (out_ready_i),
        .grant_o       (grant_o),
        .port_select_o (port_select_o),
        .out_valid_o   (out_valid_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack five 3-bit codes, index 0 (N) in the low bits.
    function automatic logic [14:0] p5(input logic [2:0] a0, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [2:0] a3,
                                       input logic [2:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic step(input string tag, input logic rst, input logic [4:0] req,
                        input logic [14:0] dest, input logic [4:0] tail, input logic [4:0] rdy,
                        input logic [4:0] eg, input logic [14:0] es, input logic [4:0] ev,
                        input logic [4:0] ee);
        exp_t  e;
        string t;
        reset       = rst;
        req_i       = req;
        dest_i      = dest;
        tail_i      = tail;
        out_ready_i = rdy;
        e.gnt = eg;
        e.sel = es;
        e.vld = ev;
        e.err = ee;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        assert ({grant_o, port_select_o, out_valid_o, err_o} === {e.gnt, e.sel, e.vld, e.err})
        else begin
            n_miss++;
            $error("FAIL %s: got gnt=%b sel=%o vld=%b err=%b, expected gnt=%b sel=%o vld=%b err=%b",
                   t, grant_o, port_select_o, out_valid_o, err_o, e.gnt, e.sel, e.vld, e.err);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        req_i       = '0;
        dest_i      = '0;
        tail_i      = '0;
        out_ready_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset cycle ignores a live request.
        step("reset_hold", 1'b1, 5'b00010, p5(X0, N, X0, X0, X0), 5'b00010, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);

        // (a) S and W contend for N with single-flit packets.
        step("a_rr_first", 1'b0, 5'b01010, p5(X0, N, X0, N, X0), ALL, ALL,
             5'b00010, p5(S, NN, NN, NN, NN), 5'b00001, 5'b00000);
        step("a_rr_second", 1'b0, 5'b01010, p5(X0, N, X0, N, X0), ALL, ALL,
             5'b01000, p5(W, NN, NN, NN, NN), 5'b00001, 5'b00000);

        // (b) E holds L for a 3-flit packet while N waits.
        step("b_head", 1'b0, 5'b00100, p5(X0, X0, L, X0, X0), 5'b00000, ALL,
             5'b00100, p5(NN, NN, NN, NN, E), 5'b10000, 5'b00000);
        step("b_body", 1'b0, 5'b00101, p5(L, X0, L, X0, X0), 5'b00001, ALL,
             5'b00100, p5(NN, NN, NN, NN, E), 5'b10000, 5'b00000);
        step("b_tail", 1'b0, 5'b00101, p5(L, X0, L, X0, X0), 5'b00101, ALL,
             5'b00100, p5(NN, NN, NN, NN, E), 5'b10000, 5'b00000);
        step("b_n_after", 1'b0, 5'b00001, p5(L, X0, X0, X0, X0), 5'b00001, ALL,
             5'b00001, p5(NN, NN, NN, NN, N), 5'b10000, 5'b00000);

        // (c) Backpressure on S during a locked packet, owner drop keeps the lock.
        step("c_head", 1'b0, 5'b00001, p5(S, X0, X0, X0, X0), 5'b00000, ALL,
             5'b00001, p5(NN, N, NN, NN, NN), 5'b00010, 5'b00000);
        step("c_stall1", 1'b0, 5'b00101, p5(S, X0, S, X0, X0), 5'b00100, 5'b11101,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);
        step("c_stall2", 1'b0, 5'b00101, p5(S, X0, S, X0, X0), 5'b00100, 5'b11101,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);
        step("c_owner_drop", 1'b0, 5'b00100, p5(S, X0, S, X0, X0), 5'b00100, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);
        step("c_tail", 1'b0, 5'b00101, p5(S, X0, S, X0, X0), 5'b00101, ALL,
             5'b00001, p5(NN, N, NN, NN, NN), 5'b00010, 5'b00000);
        step("c_e_after", 1'b0, 5'b00100, p5(X0, X0, S, X0, X0), 5'b00100, ALL,
             5'b00100, p5(NN, E, NN, NN, NN), 5'b00010, 5'b00000);

        // (d) Illegal destinations: self-route and out-of-range code.
        step("d_self", 1'b0, 5'b00011, p5(N, E, X0, X0, X0), 5'b00011, ALL,
             5'b00010, p5(NN, NN, S, NN, NN), 5'b00100, 5'b00000);
        step("d_err_n", 1'b0, 5'b00000, p5(X0, X0, X0, X0, X0), 5'b00000, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00001);
        step("d_range", 1'b0, 5'b01000, p5(X0, X0, X0, 3'b101, X0), 5'b01000, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);
        step("d_err_w", 1'b0, 5'b00000, p5(X0, X0, X0, X0, X0), 5'b00000, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b01000);

        // (e) Reset mid-packet drops W's lock on N.
        step("e_lock", 1'b0, 5'b01000, p5(X0, X0, X0, N, X0), 5'b00000, ALL,
             5'b01000, p5(W, NN, NN, NN, NN), 5'b00001, 5'b00000);
        step("e_reset", 1'b1, 5'b00010, p5(X0, N, X0, X0, X0), 5'b00010, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);
        step("e_after", 1'b0, 5'b00010, p5(X0, N, X0, X0, X0), 5'b00010, ALL,
             5'b00010, p5(S, NN, NN, NN, NN), 5'b00001, 5'b00000);

        // (f) Disjoint permutation: every input granted at once.
        step("f_all", 1'b0, ALL, p5(S, E, W, L, N), ALL, ALL,
             ALL, p5(L, N, S, E, W), ALL, 5'b00000);
        step("f_quiet", 1'b0, 5'b00000, p5(X0, X0, X0, X0, X0), 5'b00000, ALL,
             5'b00000, p5(NN, NN, NN, NN, NN), 5'b00000, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/noc_switch_alloc.md
NOC_SWITCH_ALLOC -- requirements
Module: noc_switch_alloc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the following ports, one per line:
  clk  in  1  single clock; all state updates on the rising edge
  reset  in  1  synchronous, active-high reset
  req_i  in  5  per-input-port flit valid; bit order N=0, S=1, E=2, W=3, L=4
  dest_i  in  5x3  per-input requested output-port code (N=000, S=001, E=010, W=011, L=100)
  tail_i  in  5  per-input flag: the current flit is the packet tail (a single-flit packet has tail=1)
  out_ready_i  in  5  per-output: downstream accepts a flit this cycle
  grant_o  out  5  per-input: the flit is transferred this cycle (combinational)
  port_select_o  out  5x3  per-output crossbar select carrying the source input code (combinational)
  out_valid_o  out  5  per-output: a flit is driven this cycle (combinational)
  err_o  out  5  per-input: illegal destination seen (registered, one-cycle pulse)

Function
REQ-003 Each output port SHALL run an independent two-state FSM: IDLE (no owner) and LOCKED (owner held).
REQ-004 A request is legal only if dest_i <= 100 and dest_i is not the input's own port code; illegal requests SHALL be ignored for arbitration.
REQ-005 In IDLE, an output SHALL choose one winner among legal requesters targeting it, by round robin starting at index ptr, ptr+1, ... mod 5.
REQ-006 A transfer SHALL occur in the same cycle as the winner's request when out_ready_i is 1: grant_o[winner]=1 and out_valid_o=1.
REQ-007 An IDLE transfer with tail_i=0 SHALL move the output to LOCKED with owner=winner; with tail_i=1 it SHALL stay IDLE.
REQ-008 In LOCKED, only the owner SHALL be considered; other requesters get no grant, and the owner transfers when req_i, a matching dest_i and out_ready_i are all 1.
REQ-009 A LOCKED transfer with tail_i=1 SHALL return the output to IDLE on the next edge.
REQ-010 ptr SHALL update to (source+1) mod 5 on every tail transfer and SHALL otherwise hold.
REQ-011 With out_ready_i=0, no grant SHALL occur, the state SHALL hold and ptr SHALL not advance.
REQ-012 port_select_o SHALL equal the source code whenever out_valid_o=1, and 111 otherwise.
REQ-013 Each input targets exactly one output per cycle, so grant_o[i] SHALL be the OR of the per-output grants, with at most one per input.
REQ-014 err_o[i] SHALL be 1 in the cycle after req_i[i]=1 with an illegal dest_i[i].
REQ-015 An owner that drops req_i or changes dest_i while LOCKED SHALL keep the lock (wormhole: no preemption).

Reset
REQ-016 On reset, all outputs SHALL go to IDLE with ptr=0 (N first) and owner=0.
REQ-017 On reset, err_o SHALL be 0; grant_o and out_valid_o SHALL be 0 and port_select_o SHALL be 111 during the reset cycle, regardless of inputs.
REQ-018 A reset asserted mid-packet SHALL discard all locks, and the first cycle after reset SHALL arbitrate from IDLE.

Structure
REQ-019 The shared package noc_pkg SHALL hold NUM_PORTS=5, the port_e enum (N, S, E, W, L = 0..4) and SEL_NONE=3'b111.
REQ-020 The block SHALL instantiate one sub-module per output: rr_arbiter (5-way round robin with a pointer input, a one-hot grant and an encoded grant).
REQ-021 The outputs SHALL drive the existing crossbar's per-output port-select inputs directly.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  (a) S and W both request N with tail=1 and ptr=0, all ready -> cycle 1: S granted, N select=001; cycle 2: W granted, select=011.
  (b) E sends a 3-flit packet to L while N requests L at cycle 1 -> L select=010 for 3 cycles, N blocked; then N granted, select=000.
  (c) Out_ready_i[S]=0 for 2 cycles during a locked packet -> no grant, select=111, lock held; transfer resumes when ready=1.
  (d) N requests N -> never granted; err_o[0]=1 the next cycle; other ports unaffected.
  (e) Reset asserted in the middle of a locked packet -> all outputs IDLE, ptr=0; the next request from any legal input is granted immediately.
  (f) All 5 inputs target disjoint outputs simultaneously -> all 5 grants in one cycle, each select correct.
